// File: rtl/uart8_pkg.sv
// uart8_pkg: shared definitions for the uart8 UART.
// Holds the receiver/transmitter state encodings, the frame constants and
// the constant functions that turn clock and baud rates into divider values.
package uart8_pkg;

  localparam int DATA_BITS     = 8;
  localparam int RX_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_WAIT  = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Clocks per 16x receive sample tick (integer division truncates).
  function automatic int rx_div(input int clock_rate, input int baud_rate);
    return clock_rate / (baud_rate * RX_OVERSAMPLE);
  endfunction

  // Clocks per transmitted bit.
  function automatic int tx_div(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart8_if.sv
// uart8_if: user-side signal bundle of the uart8 UART.
// Receive side : rxEn, rx in; rxBusy, rxDone, rxErr, out back.
// Transmit side: txEn, txStart, in in; txBusy, txDone, tx back.
// master = user logic / board pins driver, slave = the UART itself.
interface uart8_if;
  import uart8_pkg::*;

  logic                 rxEn;
  logic                 rx;
  logic                 rxBusy;
  logic                 rxDone;
  logic                 rxErr;
  logic [DATA_BITS-1:0] out;
  logic                 txEn;
  logic                 txStart;
  logic [DATA_BITS-1:0] in;
  logic                 txBusy;
  logic                 txDone;
  logic                 tx;

  modport master (
    output rxEn, rx, txEn, txStart, in,
    input  rxBusy, rxDone, rxErr, out, txBusy, txDone, tx
  );

  modport slave (
    input  rxEn, rx, txEn, txStart, in,
    output rxBusy, rxDone, rxErr, out, txBusy, txDone, tx
  );

endinterface

// File: rtl/uart8_baud_tick.sv
// uart8_baud_tick: free-running modulo-DIV counter used as a baud divider.
// Ports: clk, reset (sync, active-high), en_i (count enable), clr_i (restart
// at 0, wins over en_i), tick_o (one-cycle pulse, see below).
// tick_o fires on the clock *before* the counter wraps. Users register it,
// which lines the registered tick up with the wrap clock while the raw pulse
// remains available as a one-clock look-ahead. DIV must be at least 2.
module uart8_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear, wrap at DIV-1, or advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i) begin
      if (cnt_q == CW'(DIV - 1)) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == CW'(DIV - 2));

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart8.sv
// uart8: full-duplex 8N1 UART, one system clock.
// Ports: clk, reset (sync, active-high), bus (uart8_if.slave) carrying the
// receive controls/status/byte and the transmit controls/status/line.
// Receiver: 16x oversampled, mid-bit sampling, framing-error detection.
// Transmitter: 1x bit timer, LSB first. All outputs come straight from flops.
// rx is expected to be synchronous to clk already (board-level synchronizer).
module uart8
  import uart8_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input logic   clk,
  input logic   reset,
  uart8_if.slave bus
);

  localparam int RX_DIV = rx_div(CLOCK_RATE, BAUD_RATE);
  localparam int TX_DIV = tx_div(CLOCK_RATE, BAUD_RATE);
  localparam int OS_W   = $clog2(RX_OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [OS_W-1:0]  MID_TICK  = OS_W'(RX_OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  LAST_TICK = OS_W'(RX_OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  // ---------------- receiver ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [OS_W-1:0]      rx_os_cnt_q, rx_os_cnt_d;
  logic [BIT_W-1:0]     rx_bit_cnt_q, rx_bit_cnt_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] rx_out_q, rx_out_d;
  logic                 rx_busy_q, rx_busy_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_err_q, rx_err_d;
  logic                 rx_tick_q, rx_tick_d;
  logic                 rx_tick_s, rx_start_s, rx_clr_s;

  // Start detection restarts the divider so sample points count from it.
  assign rx_start_s = (rx_state_q == RX_IDLE) && bus.rxEn && !bus.rx;
  assign rx_clr_s   = !bus.rxEn || rx_start_s;

  uart8_baud_tick #(.DIV(RX_DIV)) u_rx_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (bus.rxEn),
    .clr_i  (rx_clr_s),
    .tick_o (rx_tick_s)
  );

  // Receiver next-state, shift register and status pulses.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_os_cnt_d  = rx_os_cnt_q;
    rx_bit_cnt_d = rx_bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_out_d     = rx_out_q;
    rx_done_d    = 1'b0;
    rx_err_d     = 1'b0;
    rx_tick_d    = rx_tick_s;
    if (!bus.rxEn) begin
      // Disabling drops any partial frame silently.
      rx_state_d   = RX_IDLE;
      rx_os_cnt_d  = {OS_W{1'b0}};
      rx_bit_cnt_d = {BIT_W{1'b0}};
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_start_s) begin
            rx_state_d   = RX_START;
            rx_os_cnt_d  = {OS_W{1'b0}};
            rx_bit_cnt_d = {BIT_W{1'b0}};
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
        RX_START: begin
          if (rx_tick_q) begin
            if (rx_os_cnt_q == MID_TICK) begin
              rx_os_cnt_d = {OS_W{1'b0}};
              // High at mid-start means the falling edge was a glitch.
              rx_state_d  = bus.rx ? RX_IDLE : RX_DATA;
            end else begin
              rx_os_cnt_d = rx_os_cnt_q + OS_W'(1);
            end
          end else begin
            rx_os_cnt_d = rx_os_cnt_q;
          end
        end
        RX_DATA: begin
          if (rx_tick_q) begin
            if (rx_os_cnt_q == LAST_TICK) begin
              rx_os_cnt_d = {OS_W{1'b0}};
              rx_shift_d  = {bus.rx, rx_shift_q[DATA_BITS-1:1]};
              if (rx_bit_cnt_q == LAST_BIT) begin
                rx_state_d   = RX_STOP;
                rx_bit_cnt_d = {BIT_W{1'b0}};
              end else begin
                rx_bit_cnt_d = rx_bit_cnt_q + BIT_W'(1);
              end
            end else begin
              rx_os_cnt_d = rx_os_cnt_q + OS_W'(1);
            end
          end else begin
            rx_os_cnt_d = rx_os_cnt_q;
          end
        end
        RX_STOP: begin
          if (rx_tick_q) begin
            if (rx_os_cnt_q == LAST_TICK) begin
              rx_os_cnt_d = {OS_W{1'b0}};
              if (bus.rx) begin
                rx_out_d   = rx_shift_q;
                rx_done_d  = 1'b1;
                rx_state_d = RX_IDLE;
              end else begin
                rx_err_d   = 1'b1;
                rx_state_d = RX_WAIT;
              end
            end else begin
              rx_os_cnt_d = rx_os_cnt_q + OS_W'(1);
            end
          end else begin
            rx_os_cnt_d = rx_os_cnt_q;
          end
        end
        RX_WAIT: begin
          // Hold off until the line idles so a held-low line is not a start.
          if (bus.rx) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_WAIT;
          end
        end
        default: begin
          rx_state_d = RX_IDLE;
        end
      endcase
    end
    rx_busy_d = (rx_state_d == RX_START) || (rx_state_d == RX_DATA) ||
                (rx_state_d == RX_STOP);
  end

  // Receiver registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      rx_os_cnt_q  <= {OS_W{1'b0}};
      rx_bit_cnt_q <= {BIT_W{1'b0}};
      rx_shift_q   <= {DATA_BITS{1'b0}};
      rx_out_q     <= {DATA_BITS{1'b0}};
      rx_busy_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      rx_err_q     <= 1'b0;
      rx_tick_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_os_cnt_q  <= rx_os_cnt_d;
      rx_bit_cnt_q <= rx_bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_out_q     <= rx_out_d;
      rx_busy_q    <= rx_busy_d;
      rx_done_q    <= rx_done_d;
      rx_err_q     <= rx_err_d;
      rx_tick_q    <= rx_tick_d;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [BIT_W-1:0]     tx_bit_cnt_q, tx_bit_cnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_tick_q, tx_tick_d;
  logic                 tx_tick_s, tx_start_s, tx_idle_s;

  assign tx_idle_s  = (tx_state_q == TX_IDLE);
  assign tx_start_s = tx_idle_s && bus.txEn && bus.txStart;

  // Held at 0 while idle, so each frame starts a fresh bit period.
  uart8_baud_tick #(.DIV(TX_DIV)) u_tx_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (!tx_idle_s),
    .clr_i  (tx_idle_s),
    .tick_o (tx_tick_s)
  );

  // Transmitter next-state, shift register and line level.
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_bit_cnt_d = tx_bit_cnt_q;
    tx_shift_d   = tx_shift_q;
    tx_tick_d    = tx_tick_s;
    // The raw tick is one clock early, so this lands on the stop bit's last clock.
    tx_done_d    = (tx_state_q == TX_STOP) && tx_tick_s;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start_s) begin
          tx_state_d   = TX_START;
          tx_shift_d   = bus.in;
          tx_bit_cnt_d = {BIT_W{1'b0}};
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_tick_q) begin
          tx_state_d = TX_DATA;
        end else begin
          tx_state_d = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_tick_q) begin
          if (tx_bit_cnt_q == LAST_BIT) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d   = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            tx_bit_cnt_d = tx_bit_cnt_q + BIT_W'(1);
          end
        end else begin
          tx_state_d = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tx_tick_q) begin
          tx_state_d = TX_IDLE;
        end else begin
          tx_state_d = TX_STOP;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
      end
    endcase
    case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_shift_d[0];
      default:  tx_line_d = 1'b1;
    endcase
    tx_busy_d = (tx_state_d != TX_IDLE);
  end

  // Transmitter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q   <= TX_IDLE;
      tx_bit_cnt_q <= {BIT_W{1'b0}};
      tx_shift_q   <= {DATA_BITS{1'b0}};
      tx_line_q    <= 1'b1;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_tick_q    <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_bit_cnt_q <= tx_bit_cnt_d;
      tx_shift_q   <= tx_shift_d;
      tx_line_q    <= tx_line_d;
      tx_busy_q    <= tx_busy_d;
      tx_done_q    <= tx_done_d;
      tx_tick_q    <= tx_tick_d;
    end
  end

  assign bus.rxBusy = rx_busy_q;
  assign bus.rxDone = rx_done_q;
  assign bus.rxErr  = rx_err_q;
  assign bus.out    = rx_out_q;
  assign bus.txBusy = tx_busy_q;
  assign bus.txDone = tx_done_q;
  assign bus.tx     = tx_line_q;

endmodule

// File: tb/tb_uart8.sv
// tb_uart8: directed, table-driven bench for uart8 at default rates.
module tb_uart8;
  import uart8_pkg::*;

  localparam int RX_BIT = 1248;  // 16 * 78 clocks per received bit
  localparam int TX_BIT = 1250;

  logic clk = 1'b0;
  logic reset;

  uart8_if u_if();

  uart8 u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rx_done_cnt = 0;
  int rx_err_cnt  = 0;
  int tx_done_cnt = 0;

  // Count clocks on which each status pulse is high.
  always @(negedge clk) begin
    if (u_if.rxDone === 1'b1) rx_done_cnt <= rx_done_cnt + 1;
    if (u_if.rxErr  === 1'b1) rx_err_cnt  <= rx_err_cnt + 1;
    if (u_if.txDone === 1'b1) tx_done_cnt <= tx_done_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_out;
  } rx_vec_t;

  rx_vec_t vecs[3];
  logic    tx_exp[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx"},     {31'd0, u_if.tx},     32'd1);
    check({tag, "_out"},    {24'd0, u_if.out},    32'd0);
    check({tag, "_rxBusy"}, {31'd0, u_if.rxBusy}, 32'd0);
    check({tag, "_rxDone"}, {31'd0, u_if.rxDone}, 32'd0);
    check({tag, "_rxErr"},  {31'd0, u_if.rxErr},  32'd0);
    check({tag, "_txBusy"}, {31'd0, u_if.txBusy}, 32'd0);
    check({tag, "_txDone"}, {31'd0, u_if.txDone}, 32'd0);
  endtask

  initial begin
    int         d0, e0, t0, mism;
    logic       busy0, done_at_last;
    logic [7:0] b;

    vecs[0] = '{8'h35, 1'b1, 1, 0, 8'h35};
    vecs[1] = '{8'hA5, 1'b0, 0, 1, 8'h35};  // bad stop: out keeps 0x35
    vecs[2] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    // 0x35 framed: start, 1,0,1,0,1,1,0,0, stop
    tx_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    u_if.rxEn = 1'b1; u_if.rx = 1'b1;
    u_if.txEn = 1'b1; u_if.txStart = 1'b0; u_if.in = 8'h00;
    reset = 1'b1;
    wait_clk(3);
    check_idle_outputs("reset");
    reset = 1'b0;
    wait_clk(4);

    // Receive table.
    for (int v = 0; v < 3; v++) begin
      d0 = rx_done_cnt; e0 = rx_err_cnt;
      b  = vecs[v].data;
      u_if.rx = 1'b0;
      step();
      check($sformatf("rx%0d_busy_start", v), {31'd0, u_if.rxBusy}, 32'd1);
      wait_clk(RX_BIT - 1);
      for (int i = 0; i < 8; i++) begin
        u_if.rx = b[i];
        wait_clk(RX_BIT);
      end
      u_if.rx = vecs[v].stop_b;
      wait_clk(RX_BIT);
      u_if.rx = 1'b1;
      wait_clk(16);
      check($sformatf("rx%0d_done", v), rx_done_cnt - d0, vecs[v].exp_done);
      check($sformatf("rx%0d_err", v),  rx_err_cnt - e0,  vecs[v].exp_err);
      check($sformatf("rx%0d_out", v),  {24'd0, u_if.out}, {24'd0, vecs[v].exp_out});
      check($sformatf("rx%0d_busy_end", v), {31'd0, u_if.rxBusy}, 32'd0);
    end

    // Glitch shorter than half a bit.
    d0 = rx_done_cnt; e0 = rx_err_cnt;
    u_if.rx = 1'b0;
    wait_clk(300);
    u_if.rx = 1'b1;
    wait_clk(400);
    check("glitch_busy", {31'd0, u_if.rxBusy}, 32'd0);
    check("glitch_done", rx_done_cnt - d0, 32'd0);
    check("glitch_err",  rx_err_cnt - e0,  32'd0);

    // Receiver disabled mid-frame.
    d0 = rx_done_cnt; e0 = rx_err_cnt;
    u_if.rx = 1'b0;
    wait_clk(2000);
    u_if.rxEn = 1'b0;
    step();
    check("rxen_drop_busy", {31'd0, u_if.rxBusy}, 32'd0);
    u_if.rx = 1'b1;
    wait_clk(3);
    u_if.rxEn = 1'b1;
    wait_clk(20);
    check("rxen_drop_done", rx_done_cnt - d0, 32'd0);
    check("rxen_drop_err",  rx_err_cnt - e0,  32'd0);

    // Transmit 0x35; txEn dips mid-frame, a busy-time txStart is ignored.
    t0 = tx_done_cnt;
    busy0 = 1'b0; done_at_last = 1'b0;
    u_if.in = 8'h35; u_if.txStart = 1'b1;
    for (int j = 0; j < 10; j++) begin
      mism = 0;
      for (int c = 0; c < TX_BIT; c++) begin
        step();
        if (u_if.tx !== tx_exp[j]) mism++;
        if (j == 0 && c == 0) begin
          busy0 = u_if.txBusy;
          u_if.txStart = 1'b0;
          u_if.in = 8'hFF;
        end
        if (j == 9 && c == TX_BIT - 1) done_at_last = u_if.txDone;
        if (j == 2 && c == 0) u_if.txEn = 1'b0;
        if (j == 5 && c == 0) u_if.txEn = 1'b1;
        if (j == 6 && c == 100) begin u_if.in = 8'h00; u_if.txStart = 1'b1; end
        if (j == 6 && c == 101) u_if.txStart = 1'b0;
      end
      check($sformatf("tx_bit%0d_wrong_clocks", j), mism, 32'd0);
    end
    check("tx_busy_first", {31'd0, busy0}, 32'd1);
    check("tx_done_last_clock", {31'd0, done_at_last}, 32'd1);
    step();
    check("tx_done_count", tx_done_cnt - t0, 32'd1);
    check("tx_busy_after", {31'd0, u_if.txBusy}, 32'd0);
    check("tx_idle_line", {31'd0, u_if.tx}, 32'd1);
    u_if.in = 8'h5A; u_if.txStart = 1'b1;
    step();
    u_if.txStart = 1'b0;
    check("tx_restart_line", {31'd0, u_if.tx}, 32'd0);
    check("tx_restart_busy", {31'd0, u_if.txBusy}, 32'd1);

    // Reset with both directions mid-frame.
    u_if.rx = 1'b0;
    wait_clk(2000);
    reset = 1'b1; u_if.rx = 1'b1;
    step();
    check_idle_outputs("midreset");
    reset = 1'b0;
    wait_clk(20);

    // Partial frame left hanging at the end of the run.
    d0 = rx_done_cnt; e0 = rx_err_cnt;
    b = 8'h35;
    u_if.rx = 1'b0;
    wait_clk(RX_BIT);
    for (int i = 0; i < 5; i++) begin
      u_if.rx = b[i];
      wait_clk(RX_BIT);
    end
    check("partial_busy", {31'd0, u_if.rxBusy}, 32'd1);
    check("partial_done", rx_done_cnt - d0, 32'd0);
    check("partial_err",  rx_err_cnt - e0,  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
